// File: rtl/seg_pkg.sv
// seg_pkg: segment codes (a..g, dp excluded) and update FSM encoding for seg_scan_ctrl
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;
endpackage

// File: rtl/seg_bcd_decode.sv
// seg_bcd_decode: BCD nibble to active-high a..g segments; non-decimal nibbles go dark
module seg_bcd_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with blanking, leading-zero suppression
// and a valid/ready shadow register that commits only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 16000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   value_bcd,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [0:0] st;
  logic [4*DIGITS-1:0] sh_bcd, ds_bcd;
  logic [DIGITS-1:0] sh_dp, ds_dp, lead;
  logic sh_lz, ds_lz, tc, wrap, xfer, en, blank, z;
  logic [6:0] seg_ag;
  assign tc = cnt == CW'(REFRESH_DIV - 1);
  assign wrap = tc && idx == IW'(DIGITS - 1);
  assign in_ready = st == ST_READY;
  assign xfer = in_valid && in_ready;
  assign frame_tick = wrap;
  assign en = cnt >= CW'(BLANK_CYC);
  // lead[i]: nibble i and every nibble above it are zero
  always_comb begin
    lead = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z && ds_bcd[4*i +: 4] == 4'd0;
      lead[i] = z;
    end
  end
  assign blank = ds_lz && idx != '0 && lead[idx];
  seg_bcd_decode u_dec (.bcd(ds_bcd[{idx, 2'b00} +: 4]), .seg(seg_ag));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      st <= ST_READY;
      sh_bcd <= '0;
      sh_dp <= '0;
      sh_lz <= 1'b0;
      ds_bcd <= '0;
      ds_dp <= '0;
      ds_lz <= 1'b0;
      seg <= 8'h00;
      an <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) idx <= wrap ? '0 : idx + 1'b1;
      if (xfer) begin
        sh_bcd <= value_bcd;
        sh_dp <= dp_mask;
        sh_lz <= blank_lz;
        st <= ST_PENDING;
      end else if (st == ST_PENDING && wrap) begin
        ds_bcd <= sh_bcd;
        ds_dp <= sh_dp;
        ds_lz <= sh_lz;
        st <= ST_READY;
      end
      an <= en ? DIGITS'(1) << idx : '0;
      seg <= en ? {blank ? 7'h00 : seg_ag, ds_dp[idx]} : 8'h00;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench; stimulus pushes hand-computed per-frame digit
// images, a monitor pops one entry per enabled output cycle.
module tb_seg_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, blank_lz = 1'b0;
  logic in_ready, frame_tick;
  logic [15:0] value_bcd = '0;
  logic [3:0] dp_mask = '0, an;
  logic [7:0] seg;
  logic [11:0] sb[$];
  int tests = 0, fails = 0, cyc = 0, last_tick = -1, t1 = 0;

  seg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .value_bcd(value_bcd), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // each digit is enabled for 6 cycles per slot: digit 0 first, digit 3 last
  task automatic push_frame(input logic [7:0] d3, input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    logic [7:0] s[4];
    s = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 6; r++) sb.push_back({4'(1 << k), s[k]});
  endtask

  task automatic wait_wrap();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    if (!frame_tick) check("frame_tick timeout", 16'd0, 16'd1);
  endtask

  task automatic send(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    value_bcd = v;
    dp_mask = dp;
    blank_lz = lz;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready after transfer", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
  endtask

  task automatic commit_frame(input logic [7:0] d3, input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    wait_wrap();
    check("in_ready pending at wrap", 16'(in_ready), 16'd0);
    push_frame(d3, d2, d1, d0);
    @(negedge clk);
    check("in_ready after commit", 16'(in_ready), 16'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && an != 4'd0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL display unexpected an=%h seg=%h at cycle %0d", an, seg, cyc);
      end else check("display", 16'({an, seg}), 16'(sb.pop_front()));
    end else if (rst_n) check("dark seg during blank", 16'(seg), 16'h00);
  end

  always @(negedge clk) begin
    if (!rst_n) last_tick <= -1;
    else if (frame_tick) begin
      if (last_tick >= 0) check("frame_tick period", 16'(cyc - last_tick), 16'd32);
      last_tick <= cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset seg", 16'(seg), 16'h00);
    check("reset an", 16'(an), 16'h0);
    check("reset in_ready", 16'(in_ready), 16'd1);
    check("reset frame_tick", 16'(frame_tick), 16'd0);
    rst_n = 1'b1;
    push_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);
    wait_wrap();
    push_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);
    repeat (10) @(negedge clk);
    send(16'h1234, 4'b0100, 1'b0);
    commit_frame(8'h60, 8'hDB, 8'hF2, 8'h66);
    repeat (9) @(negedge clk);
    send(16'h0070, 4'b0000, 1'b1);
    commit_frame(8'h00, 8'h00, 8'hE0, 8'hFC);
    repeat (9) @(negedge clk);
    send(16'h0000, 4'b0000, 1'b1);
    commit_frame(8'h00, 8'h00, 8'h00, 8'hFC);
    wait_wrap();
    push_frame(8'h00, 8'h00, 8'h00, 8'hFC);
    value_bcd = 16'h0865;
    dp_mask = 4'b0001;
    blank_lz = 1'b0;
    in_valid = 1'b1;
    t1 = cyc;
    @(negedge clk);
    check("in_ready after wrap transfer", 16'(in_ready), 16'd0);
    value_bcd = 16'h9999;
    dp_mask = 4'b1111;
    wait_wrap();
    check("commit delay", 16'(cyc - t1), 16'd32);
    check("in_ready held pending", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
    push_frame(8'hFC, 8'hFE, 8'hBE, 8'hB7);
    @(negedge clk);
    check("in_ready after delayed commit", 16'(in_ready), 16'd1);
    repeat (9) @(negedge clk);
    send(16'h3A1A, 4'b0100, 1'b0);
    commit_frame(8'hF2, 8'h01, 8'h60, 8'h00);
    repeat (12) @(negedge clk);
    send(16'h8888, 4'b1111, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("async reset seg", 16'(seg), 16'h00);
    check("async reset an", 16'(an), 16'h0);
    check("async reset in_ready", 16'(in_ready), 16'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);
    wait_wrap();
    push_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);
    check("in_ready after reset", 16'(in_ready), 16'd1);
    wait_wrap();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
